tick_gen_prog: RTL

//  Programmable clock-enable (tick) generator; successor to the fixed 1 s RCO counter.

---
 rtl/clk_pkg.sv | 18 +
 rtl/mod_counter.sv | 37 +++
 rtl/tick_gen_prog.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clk_pkg.sv
// Shared constants and types for the timekeeping tick chain.
package clk_pkg;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned PERIOD_1HZ      = CLK_HZ;
  localparam int unsigned PERIOD_1KHZ     = CLK_HZ / 1000;
  localparam int unsigned SUB_DIV_SEC_MIN = 60;
  localparam int unsigned SUB_DIV_MIN_HR  = 60;
  localparam int unsigned SUB_DIV_HR_DAY  = 24;

  // One-shot arming state; ARMED encoded as 1 so the state bit is the armed flag.
  typedef enum logic {
    ST_DONE  = 1'b0,
    ST_ARMED = 1'b1
  } arm_state_t;

endpackage

// File: rtl/mod_counter.sv
// Fixed-modulus enable counter with a registered wrap pulse.
module mod_counter #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 60
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Count 0..MODULUS-1 on enable; wrap pulses on the cycle the count returns to 0.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      if (value >= LAST) begin
        value <= '0;
        wrap  <= 1'b1;
      end else begin
        value <= value + WIDTH'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_gen_prog.sv
// Programmable tick generator: run-time period main stage plus fixed sub-divider.
module tick_gen_prog
  import clk_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PERIOD_RST = 50000000,
  parameter int unsigned SUB_DIV    = 60,
  parameter int unsigned SUB_W      = 6
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  input  logic             oneshot,
  input  logic             start,
  output logic             tick,
  output logic             tick_sub,
  output logic [CNT_W-1:0] count,
  output logic             armed
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] shadow;
  logic             pending;
  arm_state_t       state;
  arm_state_t       state_nxt;

  logic             load_now_c;
  logic [CNT_W-1:0] period_use_c;
  logic [CNT_W-1:0] last_c;
  logic             at_end_c;
  logic             run_c;
  logic             wrap_c;
  logic [SUB_W-1:0] sub_value;
  logic             unused_ok;

  // Compare against the period that governs this edge; an immediate load takes effect now.
  always_comb begin
    load_now_c   = load && (count == '0);
    period_use_c = load_now_c ? period_in : period;
    last_c       = (period_use_c == '0) ? '0 : period_use_c - ONE;
    at_end_c     = (count >= last_c);
    run_c        = !clr && en && (state == ST_ARMED);
    wrap_c       = run_c && at_end_c;
  end

  // One-shot state register.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state <= ST_ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  // Disarm after a one-shot tick; re-arm on start or when leaving one-shot mode.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_ARMED;
    end else if (en) begin
      case (state)
        ST_ARMED: if (wrap_c && oneshot)    state_nxt = ST_DONE;
        ST_DONE:  if (start || !oneshot)    state_nxt = ST_ARMED;
        default:                            state_nxt = ST_ARMED;
      endcase
    end
  end

  assign armed = (state == ST_ARMED);

  // Main counter and tick pulse.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (run_c) begin
      tick  <= at_end_c;
      count <= at_end_c ? '0 : count + ONE;
    end else begin
      tick <= 1'b0;
    end
  end

  // Period shadow: new period lands at a wrap, at count 0, or together with clr.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      period  <= PERIOD_INIT;
      shadow  <= PERIOD_INIT;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= period_in;
      if (clr) begin
        if (load)         period <= period_in;
        else if (pending) period <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        if (load_now_c || wrap_c) begin
          period  <= period_in;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end else if (wrap_c && pending) begin
        period  <= shadow;
        pending <= 1'b0;
      end
    end
  end

  // Sub stage advances on each main tick; its wrap is tick_sub.
  mod_counter #(
    .WIDTH   (SUB_W),
    .MODULUS (SUB_DIV)
  ) u_sub (
    .mclk  (mclk),
    .reset (reset),
    .en    (wrap_c),
    .clr   (clr),
    .value (sub_value),
    .wrap  (tick_sub)
  );

  // Sub count is internal only.
  assign unused_ok = ^sub_value;

endmodule
